mgt_01_div_ctrl: RTL and testbench

Sequencer and front end for the iterative MGT-01 divider (`MGT_01_div_unit`), sitting between the M-extension issue stage and the divider.
- Accepts one DIV/DIVU/REM/REMU request at a time over a valid/ready handshake.
- Resolves RISC-V special cases (divide-by-zero, signed overflow) without engaging the divider.
- Otherwise clock-enables the divider until it returns FREE, then holds a tagged response until the writeback stage takes it.

---
 rtl/mgt_01_div_ctrl_pkg.sv | 37 +++
 rtl/mgt_01_div_special_detect.sv | 56 +++++
 rtl/mgt_01_div_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_mgt_01_div_ctrl.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mgt_01_div_ctrl_pkg.sv
// Shared types and constants for the MGT-01 divider controller.
// Optional reuse store is enabled by defining MGT_01_DIV_REUSE_EN.
package mgt_01_div_ctrl_pkg;

  localparam int XLEN  = 32;
  localparam int TAG_W = 5;

  typedef enum logic [1:0] {
    DIV_  = 2'b00,
    DIVU_ = 2'b01,
    REM_  = 2'b10,
    REMU_ = 2'b11
  } div_ops_e;

  typedef enum logic {
    FREE = 1'b0,
    BUSY = 1'b1
  } fu_state_e;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    CAPT_ALT = 2'd2,
    RESP     = 2'd3
  } div_ctrl_state_e;

  localparam logic [XLEN-1:0] DIV_OVF_DIVIDEND = 32'h8000_0000;
  localparam logic [XLEN-1:0] DIV_ALL_ONES     = '1;

  // Bit 1 selects quotient/remainder, so flipping it pairs DIV_<->REM_ and DIVU_<->REMU_.
  function automatic div_ops_e paired_op(input div_ops_e op);
    logic [1:0] v;
    v = op;
    return div_ops_e'(v ^ 2'b10);
  endfunction

endpackage

// File: rtl/mgt_01_div_special_detect.sv
// Combinational RISC-V divide special-case classifier (divide-by-zero, signed overflow).
module mgt_01_div_special_detect
  import mgt_01_div_ctrl_pkg::*;
(
  input  div_ops_e        op_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic            hit_o,
  output logic [XLEN-1:0] result_o
);

  logic div_zero;
  logic ovf;

  assign div_zero = (divisor_i == '0);
  assign ovf      = (dividend_i == DIV_OVF_DIVIDEND) && (divisor_i == DIV_ALL_ONES);

  always_comb begin
    hit_o    = 1'b0;
    result_o = '0;
    unique case (op_i)
      DIV_: begin
        if (div_zero) begin
          hit_o    = 1'b1;
          result_o = DIV_ALL_ONES;
        end else if (ovf) begin
          hit_o    = 1'b1;
          result_o = DIV_OVF_DIVIDEND;
        end
      end
      DIVU_: begin
        if (div_zero) begin
          hit_o    = 1'b1;
          result_o = DIV_ALL_ONES;
        end
      end
      REM_: begin
        if (div_zero) begin
          hit_o    = 1'b1;
          result_o = dividend_i;
        end else if (ovf) begin
          hit_o    = 1'b1;
          result_o = '0;
        end
      end
      REMU_: begin
        if (div_zero) begin
          hit_o    = 1'b1;
          result_o = dividend_i;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mgt_01_div_ctrl.sv
// Request/response sequencer in front of the iterative MGT-01 divider.
// Define MGT_01_DIV_REUSE_EN to add the CAPT_ALT state and the paired-op reuse store.
module mgt_01_div_ctrl
  import mgt_01_div_ctrl_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  div_ops_e         req_op_i,
  input  logic [XLEN-1:0]  req_dividend_i,
  input  logic [XLEN-1:0]  req_divisor_i,
  input  logic [TAG_W-1:0] req_tag_i,
  input  logic             flush_i,
  output logic             resp_valid_o,
  input  logic             resp_ready_i,
  output logic [XLEN-1:0]  resp_data_o,
  output logic [TAG_W-1:0] resp_tag_o,
  output logic [XLEN-1:0]  div_dividend_o,
  output logic [XLEN-1:0]  div_divisor_o,
  output div_ops_e         div_op_o,
  output logic             div_clk_en_o,
  output logic             div_rst_n_o,
  input  fu_state_e        div_fu_state_i,
  input  logic [XLEN-1:0]  div_result_i,
  output fu_state_e        fu_state_o
);

  div_ctrl_state_e  state_q, state_d;
  logic             busy_seen_q, busy_seen_d;
  div_ops_e         op_q, op_d;
  logic [XLEN-1:0]  dividend_q, dividend_d;
  logic [XLEN-1:0]  divisor_q, divisor_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [XLEN-1:0]  data_q, data_d;
  logic             abort_q, abort_d;
  logic             accept;
  logic             sp_hit;
  logic [XLEN-1:0]  sp_result;

`ifdef MGT_01_DIV_REUSE_EN
  logic             st_vld_q, st_vld_d;
  logic [XLEN-1:0]  st_dividend_q, st_dividend_d;
  logic [XLEN-1:0]  st_divisor_q, st_divisor_d;
  div_ops_e         st_op_q, st_op_d;
  logic [XLEN-1:0]  st_data_q, st_data_d;
  logic             st_hit;

  // Op equality also implies equal signedness.
  assign st_hit = st_vld_q && (req_dividend_i == st_dividend_q)
                  && (req_divisor_i == st_divisor_q) && (req_op_i == st_op_q);
`endif

  mgt_01_div_special_detect u_special (
    .op_i       (req_op_i),
    .dividend_i (req_dividend_i),
    .divisor_i  (req_divisor_i),
    .hit_o      (sp_hit),
    .result_o   (sp_result)
  );

  assign req_ready_o    = (state_q == IDLE) & ~flush_i;
  assign accept         = req_valid_i & req_ready_o;
  assign resp_data_o    = data_q;
  assign resp_tag_o     = tag_q;
  assign div_dividend_o = dividend_q;
  assign div_divisor_o  = divisor_q;
  assign fu_state_o     = (state_q == IDLE) ? FREE : BUSY;
  // The abort pulse is registered; reset itself also holds the divider in reset.
  assign div_rst_n_o    = rst_n_i & ~abort_q;

  always_comb begin
    state_d      = state_q;
    busy_seen_d  = busy_seen_q;
    op_d         = op_q;
    dividend_d   = dividend_q;
    divisor_d    = divisor_q;
    tag_d        = tag_q;
    data_d       = data_q;
    abort_d      = 1'b0;
    div_clk_en_o = 1'b0;
    div_op_o     = op_q;
    resp_valid_o = 1'b0;
`ifdef MGT_01_DIV_REUSE_EN
    st_vld_d      = st_vld_q;
    st_dividend_d = st_dividend_q;
    st_divisor_d  = st_divisor_q;
    st_op_d       = st_op_q;
    st_data_d     = st_data_q;
`endif

    unique case (state_q)
      IDLE: begin
        busy_seen_d = 1'b0;
        if (accept) begin
          op_d       = req_op_i;
          dividend_d = req_dividend_i;
          divisor_d  = req_divisor_i;
          tag_d      = req_tag_i;
          if (sp_hit) begin
            data_d  = sp_result;
            state_d = RESP;
`ifdef MGT_01_DIV_REUSE_EN
          end else if (st_hit) begin
            data_d  = st_data_q;
            state_d = RESP;
`endif
          end else begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        div_clk_en_o = 1'b1;
        if (div_fu_state_i == BUSY) busy_seen_d = 1'b1;
        if (busy_seen_q && (div_fu_state_i == FREE)) begin
          div_clk_en_o = 1'b0;
          data_d       = div_result_i;
`ifdef MGT_01_DIV_REUSE_EN
          state_d      = CAPT_ALT;
`else
          state_d      = RESP;
`endif
        end
      end
`ifdef MGT_01_DIV_REUSE_EN
      CAPT_ALT: begin
        div_op_o      = paired_op(op_q);
        st_vld_d      = 1'b1;
        st_dividend_d = dividend_q;
        st_divisor_d  = divisor_q;
        st_op_d       = paired_op(op_q);
        st_data_d     = div_result_i;
        state_d       = RESP;
      end
`endif
      RESP: begin
        resp_valid_o = 1'b1;
        if (resp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (flush_i) begin
      state_d     = IDLE;
      busy_seen_d = 1'b0;
      if ((state_q == RUN) || (state_q == CAPT_ALT)) begin
        abort_d = 1'b1;
`ifdef MGT_01_DIV_REUSE_EN
        st_vld_d = 1'b0;
`endif
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= IDLE;
      busy_seen_q <= 1'b0;
      op_q        <= DIV_;
      dividend_q  <= '0;
      divisor_q   <= '0;
      tag_q       <= '0;
      data_q      <= '0;
      abort_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      busy_seen_q <= busy_seen_d;
      op_q        <= op_d;
      dividend_q  <= dividend_d;
      divisor_q   <= divisor_d;
      tag_q       <= tag_d;
      data_q      <= data_d;
      abort_q     <= abort_d;
    end
  end

`ifdef MGT_01_DIV_REUSE_EN
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      st_vld_q      <= 1'b0;
      st_dividend_q <= '0;
      st_divisor_q  <= '0;
      st_op_q       <= DIV_;
      st_data_q     <= '0;
    end else begin
      st_vld_q      <= st_vld_d;
      st_dividend_q <= st_dividend_d;
      st_divisor_q  <= st_divisor_d;
      st_op_q       <= st_op_d;
      st_data_q     <= st_data_d;
    end
  end
`endif

endmodule

// File: tb/tb_mgt_01_div_ctrl.sv
// Directed self-checking bench for mgt_01_div_ctrl with a small behavioural divider.
module tb_mgt_01_div_ctrl;
  import mgt_01_div_ctrl_pkg::*;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             req_valid;
  logic             req_ready;
  div_ops_e         req_op;
  logic [XLEN-1:0]  req_dividend;
  logic [XLEN-1:0]  req_divisor;
  logic [TAG_W-1:0] req_tag;
  logic             flush;
  logic             resp_valid;
  logic             resp_ready;
  logic [XLEN-1:0]  resp_data;
  logic [TAG_W-1:0] resp_tag;
  logic [XLEN-1:0]  div_dividend;
  logic [XLEN-1:0]  div_divisor;
  div_ops_e         div_op;
  logic             div_clk_en;
  logic             div_rst_n;
  fu_state_e        div_fu_state;
  logic [XLEN-1:0]  div_result;
  fu_state_e        fu_state;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mgt_01_div_ctrl dut (
    .clk_i          (clk),
    .rst_n_i        (rst_n),
    .req_valid_i    (req_valid),
    .req_ready_o    (req_ready),
    .req_op_i       (req_op),
    .req_dividend_i (req_dividend),
    .req_divisor_i  (req_divisor),
    .req_tag_i      (req_tag),
    .flush_i        (flush),
    .resp_valid_o   (resp_valid),
    .resp_ready_i   (resp_ready),
    .resp_data_o    (resp_data),
    .resp_tag_o     (resp_tag),
    .div_dividend_o (div_dividend),
    .div_divisor_o  (div_divisor),
    .div_op_o       (div_op),
    .div_clk_en_o   (div_clk_en),
    .div_rst_n_o    (div_rst_n),
    .div_fu_state_i (div_fu_state),
    .div_result_i   (div_result),
    .fu_state_o     (fu_state)
  );

  // Behavioural divider: starts when enabled, BUSY for 4 enabled cycles, then FREE.
  logic       busy_m;
  logic       started_m;
  logic [2:0] cnt_m;

  always @(posedge clk) begin
    if (!div_rst_n) begin
      busy_m    <= 1'b0;
      started_m <= 1'b0;
      cnt_m     <= '0;
    end else if (div_clk_en) begin
      if (!started_m) begin
        started_m <= 1'b1;
        busy_m    <= 1'b1;
        cnt_m     <= 3'd4;
      end else if (busy_m) begin
        cnt_m <= cnt_m - 3'd1;
        if (cnt_m == 3'd1) busy_m <= 1'b0;
      end
    end else begin
      started_m <= 1'b0;
    end
  end

  function automatic logic [31:0] div_model(input div_ops_e op, input logic [31:0] a,
                                            input logic [31:0] b);
    if (b == 0) return '0;
    case (op)
      DIV_:    return $signed(a) / $signed(b);
      DIVU_:   return a / b;
      REM_:    return $signed(a) % $signed(b);
      default: return a % b;
    endcase
  endfunction

  assign div_fu_state = busy_m ? BUSY : FREE;
  assign div_result   = div_model(div_op, div_dividend, div_divisor);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_req(input div_ops_e op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] tag);
    @(negedge clk);
    req_valid    = 1'b1;
    req_op       = op;
    req_dividend = a;
    req_divisor  = b;
    req_tag      = tag;
    @(negedge clk);
    req_valid    = 1'b0;
  endtask

  // Called at the first negedge after the accept edge; lat counts edges since accept.
  task automatic wait_resp(output int lat, output bit en_seen, output bit busy_all);
    lat      = 1;
    en_seen  = 1'b0;
    busy_all = 1'b1;
    while (!resp_valid && lat < 200) begin
      en_seen = en_seen | div_clk_en;
      if (fu_state != BUSY) busy_all = 1'b0;
      @(negedge clk);
      lat++;
    end
    chk("resp_valid_timeout", {31'd0, resp_valid}, 32'd1);
  endtask

  task automatic take_resp();
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
  endtask

  int lat;
  bit en_seen;
  bit busy_all;

  initial begin
    rst_n        = 1'b0;
    req_valid    = 1'b0;
    req_op       = DIV_;
    req_dividend = '0;
    req_divisor  = '0;
    req_tag      = '0;
    flush        = 1'b0;
    resp_ready   = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_div_rst_n_low", {31'd0, div_rst_n}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_resp_data", resp_data, 32'd0);
    chk("rst_resp_tag", {27'd0, resp_tag}, 32'd0);
    chk("rst_clk_en", {31'd0, div_clk_en}, 32'd0);
    chk("rst_div_rst_n_high", {31'd0, div_rst_n}, 32'd1);
    chk("rst_fu_state", {31'd0, fu_state}, {31'd0, FREE});

    // DIV 100/7 through the divider
    do_req(DIV_, 32'd100, 32'd7, 5'd3);
    wait_resp(lat, en_seen, busy_all);
    chk("div_clk_en_seen", {31'd0, en_seen}, 32'd1);
    chk("div_fu_busy", {31'd0, busy_all}, 32'd1);
    chk("div_data", resp_data, 32'd14);
    chk("div_tag", {27'd0, resp_tag}, 32'd3);
    take_resp();

    // Divide-by-zero special cases
    do_req(DIVU_, 32'h1234, 32'd0, 5'd1);
    wait_resp(lat, en_seen, busy_all);
    chk("divu0_lat", lat, 32'd1);
    chk("divu0_data", resp_data, 32'hFFFF_FFFF);
    chk("divu0_no_en", {31'd0, en_seen | div_clk_en}, 32'd0);
    take_resp();
    do_req(REMU_, 32'h1234, 32'd0, 5'd2);
    wait_resp(lat, en_seen, busy_all);
    chk("remu0_lat", lat, 32'd1);
    chk("remu0_data", resp_data, 32'h1234);
    take_resp();

    // Signed overflow special cases
    do_req(DIV_, 32'h8000_0000, 32'hFFFF_FFFF, 5'd4);
    wait_resp(lat, en_seen, busy_all);
    chk("ovf_div_lat", lat, 32'd1);
    chk("ovf_div_data", resp_data, 32'h8000_0000);
    chk("ovf_div_no_en", {31'd0, en_seen | div_clk_en}, 32'd0);
    take_resp();
    do_req(REM_, 32'h8000_0000, 32'hFFFF_FFFF, 5'd5);
    wait_resp(lat, en_seen, busy_all);
    chk("ovf_rem_lat", lat, 32'd1);
    chk("ovf_rem_data", resp_data, 32'd0);
    take_resp();

    // Backpressure: REMU 20/3 held for 5 cycles
    do_req(REMU_, 32'd20, 32'd3, 5'd9);
    wait_resp(lat, en_seen, busy_all);
    for (int i = 0; i < 5; i++) begin
      chk("hold_data", resp_data, 32'd2);
      chk("hold_tag", {27'd0, resp_tag}, 32'd9);
      chk("hold_valid", {31'd0, resp_valid}, 32'd1);
      chk("hold_req_ready", {31'd0, req_ready}, 32'd0);
      @(negedge clk);
    end
    take_resp();
    chk("post_hs_idle", {31'd0, fu_state}, {31'd0, FREE});
    chk("post_hs_valid", {31'd0, resp_valid}, 32'd0);
    chk("post_hs_ready", {31'd0, req_ready}, 32'd1);

    // Flush mid-RUN
    do_req(DIV_, 32'd1000, 32'd9, 5'd7);
    repeat (2) @(negedge clk);
    chk("pre_flush_en", {31'd0, div_clk_en}, 32'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_div_rst_low", {31'd0, div_rst_n}, 32'd0);
    chk("flush_no_valid", {31'd0, resp_valid}, 32'd0);
    chk("flush_idle", {31'd0, fu_state}, {31'd0, FREE});
    @(negedge clk);
    chk("flush_div_rst_high", {31'd0, div_rst_n}, 32'd1);
    repeat (8) @(negedge clk);
    chk("flush_still_no_valid", {31'd0, resp_valid}, 32'd0);
    do_req(DIVU_, 32'd50, 32'd5, 5'd6);
    wait_resp(lat, en_seen, busy_all);
    chk("after_flush_data", resp_data, 32'd10);
    chk("after_flush_tag", {27'd0, resp_tag}, 32'd6);
    take_resp();

    // Paired-op reuse: DIV 100/7 then REM 100/7
    do_req(DIV_, 32'd100, 32'd7, 5'd10);
    wait_resp(lat, en_seen, busy_all);
    chk("pair_div_data", resp_data, 32'd14);
    take_resp();
    do_req(REM_, 32'd100, 32'd7, 5'd11);
    wait_resp(lat, en_seen, busy_all);
    chk("pair_rem_data", resp_data, 32'd2);
    chk("pair_rem_tag", {27'd0, resp_tag}, 32'd11);
`ifdef MGT_01_DIV_REUSE_EN
    chk("pair_rem_lat", lat, 32'd1);
`else
    chk("pair_rem_full_latency", {31'd0, (lat > 3)}, 32'd1);
`endif
    take_resp();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
